// File: rtl/ecc_frame_rx.sv
// Receive-side SEC-DED link endpoint: deserialises start/16-bit/stop frames,
// decodes Hamming(15,11)+overall parity, and presents 11-bit packets on a
// valid/ready interface with correction flags and saturating error counters.
module ecc_frame_rx #(
  parameter int PACKET_SIZE = 11,
  parameter int FRAME_SIZE  = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_bit,
  input  logic                   rx_strobe,
  output logic [PACKET_SIZE-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_corrected,
  output logic                   out_uncorr,
  output logic                   framing_err,
  output logic                   overrun,
  output logic [CNT_WIDTH-1:0]   corr_cnt,
  output logic [CNT_WIDTH-1:0]   uncorr_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    STOP,
    BREAK,
    DECODE
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            idx;
  logic [FRAME_SIZE-1:0] frame;

  logic [3:0]             syn;
  logic                   o2;
  logic [FRAME_SIZE-1:0]  fixed;
  logic [PACKET_SIZE-1:0] dec_data;
  logic                   dec_corr;
  logic                   dec_uncorr;
  logic                   load;

  // Line FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Line FSM next-state: only strobed cycles advance, except DECODE which is one cycle.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (rx_strobe && !rx_bit)        state_nxt = DATA;
      DATA:    if (rx_strobe && idx == 4'd15)   state_nxt = STOP;
      STOP:    if (rx_strobe)                   state_nxt = rx_bit ? DECODE : BREAK;
      BREAK:   if (rx_strobe && rx_bit)         state_nxt = IDLE;
      DECODE:                                   state_nxt = IDLE;
      default:                                  state_nxt = IDLE;
    endcase
  end

  // Bit index within the code field; cleared whenever the line is idle.
  always_ff @(posedge clk) begin
    if (rst)                            idx <= 4'd0;
    else if (state == IDLE)             idx <= 4'd0;
    else if (state == DATA && rx_strobe) idx <= idx + 4'd1;
  end

  // Codeword capture, LSB first.
  always_ff @(posedge clk) begin
    // NOTE: the frame buffer is not reset: every bit is rewritten before it is
    // decoded, so a reset here would only add fanout on rst.
    if (state == DATA && rx_strobe) frame[idx] <= rx_bit;
  end

  // SEC-DED decode of the captured frame: syndrome, overall parity, correction, extraction.
  always_comb begin
    syn = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (frame[i]) syn = syn ^ 4'(i + 1);
    end
    o2    = ^frame;
    fixed = frame;
    if (syn != 4'd0 && o2) fixed[syn - 4'd1] = ~frame[syn - 4'd1];
    dec_corr   = o2;
    dec_uncorr = (syn != 4'd0) && !o2;
    dec_data   = {fixed[14:8], fixed[6:4], fixed[2]};
  end

  assign load = (state == DECODE) && (!out_valid || out_ready);

  // Output register, handshake, event pulses and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_corrected <= 1'b0;
      out_uncorr    <= 1'b0;
      framing_err   <= 1'b0;
      overrun       <= 1'b0;
      corr_cnt      <= '0;
      uncorr_cnt    <= '0;
    end else begin
      framing_err <= (state == STOP) && rx_strobe && !rx_bit;
      overrun     <= (state == DECODE) && !load;
      if (load) begin
        out_data      <= dec_data;
        out_corrected <= dec_corr;
        out_uncorr    <= dec_uncorr;
        out_valid     <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // Counters track every decoded frame, including ones dropped on overrun.
      if (state == DECODE) begin
        if (dec_corr && corr_cnt != '1)     corr_cnt   <= corr_cnt + 1'b1;
        if (dec_uncorr && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ecc_frame_rx.sv
// Self-checking bench for ecc_frame_rx: directed frames plus randomized
// packets with injected 0/1/2-bit errors, checked against a packet-level model.
module tb_ecc_frame_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_bit = 1'b1;
  logic        rx_strobe = 1'b0;
  logic        out_ready = 1'b0;
  logic [10:0] out_data;
  logic        out_valid;
  logic        out_corrected;
  logic        out_uncorr;
  logic        framing_err;
  logic        overrun;
  logic [7:0]  corr_cnt;
  logic [7:0]  uncorr_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  // Expected accepted packets: {uncorr, corrected, data}.
  logic [12:0] exp_q[$];
  int mc_corr = 0;
  int mc_unc  = 0;
  int fe_seen = 0;
  int ov_seen = 0;
  bit rand_ready = 1'b0;
  bit ready_fix  = 1'b0;

  ecc_frame_rx dut (
    .clk          (clk),
    .rst          (rst),
    .rx_bit       (rx_bit),
    .rx_strobe    (rx_strobe),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_corrected(out_corrected),
    .out_uncorr   (out_uncorr),
    .framing_err  (framing_err),
    .overrun      (overrun),
    .corr_cnt     (corr_cnt),
    .uncorr_cnt   (uncorr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hamming positions (1-based) of data bits d3,d5,d6,d7,d9..d15 in packet order.
  function automatic int dpos(input int k);
    int p[11];
    p = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    return p[k];
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    int pw;
    c = '0;
    for (int k = 0; k < 11; k++) c[dpos(k) - 1] = d[k];
    for (int j = 0; j < 4; j++) begin
      pw = 1 << j;
      for (int pos = 1; pos < 16; pos++)
        if ((pos & pw) != 0 && pos != pw) c[pw - 1] = c[pw - 1] ^ c[pos - 1];
    end
    c[15] = ^c[14:0];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d;
    for (int k = 0; k < 11; k++) d[k] = c[dpos(k) - 1];
    return d;
  endfunction

  // Output ready: either a fixed level or a coin flip per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  // Scoreboard: every accepted packet must match the next expected one.
  always @(negedge clk) begin : monitor
    logic [12:0] e;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[10:0]));
        check("out_corrected", 32'(out_corrected), 32'(e[11]));
        check("out_uncorr", 32'(out_uncorr), 32'(e[12]));
      end
    end
  end

  always @(negedge clk) begin
    if (framing_err === 1'b1) fe_seen++;
    if (overrun === 1'b1)     ov_seen++;
  end

  task automatic strobe(input logic b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk);
    #1;
    rx_bit    = b;
    rx_strobe = 1'b1;
    @(posedge clk);
    #1;
    rx_strobe = 1'b0;
    rx_bit    = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] cw, input logic stop_bit);
    strobe(1'b0);
    for (int i = 0; i < 16; i++) strobe(cw[i]);
    strobe(stop_bit);
  endtask

  // Record the model's view of one decoded frame, then put it on the line.
  task automatic send_expect(input logic [15:0] cw, input logic [10:0] d,
                             input logic corr, input logic unc, input bit loaded);
    if (loaded) exp_q.push_back({unc, corr, d});
    if (corr && mc_corr < 255) mc_corr++;
    if (unc && mc_unc < 255)   mc_unc++;
    send_frame(cw, 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_counters(input string tag);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_corr_cnt"}, 32'(corr_cnt), 32'(mc_corr));
    check({tag, "_uncorr_cnt"}, 32'(uncorr_cnt), 32'(mc_unc));
  endtask

  // Random packet with 0, 1 or 2 distinct flipped bits; model from error count.
  task automatic send_random(input int nflip);
    logic [10:0] pkt;
    logic [15:0] cw;
    int p1, p2;
    pkt = 11'($urandom);
    cw  = encode(pkt);
    p1  = $urandom_range(0, 15);
    p2  = (p1 + $urandom_range(1, 15)) % 16;
    if (nflip >= 1) cw[p1] = ~cw[p1];
    if (nflip == 2) cw[p2] = ~cw[p2];
    if (nflip == 2) send_expect(cw, extract(cw), 1'b0, 1'b1, 1'b1);
    else            send_expect(cw, pkt, nflip == 1, 1'b0, 1'b1);
  endtask

  initial begin
    int fe0, ov0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_flags", 32'({out_corrected, out_uncorr, framing_err, overrun}), 32'd0);
    check("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_fix = 1'b1;

    // Clean frame and exact output latency.
    exp_q.push_back({1'b0, 1'b0, 11'h001});
    send_frame(16'h8007, 1'b1);
    @(negedge clk);
    check("lat_early_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'd1);
    wait_drain();

    // Known single/double error codewords.
    send_expect(16'h8003, 11'h001, 1'b1, 1'b0, 1'b1);
    wait_drain();
    check_counters("d3_flip");
    send_expect(16'h8013, 11'h002, 1'b0, 1'b1, 1'b1);
    wait_drain();
    check_counters("double");
    send_expect(16'h0007, 11'h001, 1'b1, 1'b0, 1'b1);
    send_expect(16'h8006, 11'h001, 1'b1, 1'b0, 1'b1);
    wait_drain();
    check_counters("parity_flip");

    // Framing error: one pulse, nothing output, break must wait for a high line.
    fe0 = fe_seen;
    send_frame(encode(11'h3C5), 1'b0);
    repeat (3) @(negedge clk);
    check("framing_pulse", 32'(fe_seen - fe0), 32'd1);
    check("framing_no_valid", 32'(out_valid), 32'd0);
    strobe(1'b0);
    strobe(1'b0);
    strobe(1'b1);
    send_expect(encode(11'h3C5), 11'h3C5, 1'b0, 1'b0, 1'b1);
    wait_drain();
    check_counters("after_break");

    // Overrun: first frame held, second dropped with one pulse.
    ready_fix = 1'b0;
    ov0 = ov_seen;
    send_expect(encode(11'h155), 11'h155, 1'b0, 1'b0, 1'b1);
    send_expect(encode(11'h2AA), 11'h2AA, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("overrun_pulse", 32'(ov_seen - ov0), 32'd1);
    check("held_valid", 32'(out_valid), 32'd1);
    check("held_data", 32'(out_data), 32'h155);
    ready_fix = 1'b1;
    wait_drain();
    repeat (2) @(negedge clk);
    check("drained_valid", 32'(out_valid), 32'd0);

    // Randomized frames under random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      send_random($urandom_range(0, 2));
      wait_drain();
    end
    check_counters("random");
    rand_ready = 1'b0;

    // Uncorrectable counter saturation.
    for (int n = 0; n < 300; n++) send_random(2);
    wait_drain();
    check_counters("saturate");
    check("uncorr_sat_255", 32'(uncorr_cnt), 32'd255);

    // Reset in the middle of a frame, then a clean frame.
    strobe(1'b0);
    for (int i = 0; i < 5; i++) strobe(1'($urandom_range(0, 1)));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mc_corr = 0;
    mc_unc  = 0;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
    send_expect(encode(11'h4A9), 11'h4A9, 1'b0, 1'b0, 1'b1);
    wait_drain();
    check_counters("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
